// File: rtl/fetch_wave_scheduler_if.sv
// Instruction-memory request/response channel between the wave fetch
// scheduler (master) and the instruction memory (slave).
interface fetch_wave_scheduler_if #(
    parameter int PC_W   = 32,
    parameter int WFID_W = 6
);
    logic              ip_req_valid;
    logic              ip_req_ready;
    logic [PC_W-1:0]   ip_req_pc;
    logic [WFID_W-1:0] ip_req_wfid;
    logic              ip_resp_valid;
    logic [31:0]       ip_resp_instr;

    modport master (
        output ip_req_valid, ip_req_pc, ip_req_wfid,
        input  ip_req_ready, ip_resp_valid, ip_resp_instr
    );

    modport slave (
        input  ip_req_valid, ip_req_pc, ip_req_wfid,
        output ip_req_ready, ip_resp_valid, ip_resp_instr
    );
endinterface

// File: rtl/fetch_wave_scheduler.sv
// Wavefront fetch scheduler: tracks PC/active per wavefront slot, grants one
// eligible slot round-robin, keeps a single instruction-memory request in
// flight and pulses fetch_valid with the returned instruction.
module fetch_wave_scheduler #(
    parameter int NUM_WF = 40,
    parameter int WFID_W = 6,
    parameter int PC_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wf_dispatch_i,
    input  logic [WFID_W-1:0]    dispatch_wfid,
    input  logic [PC_W-1:0]      dispatch_pc,
    input  logic                 wf_halt,
    input  logic [WFID_W-1:0]    halt_wfid,
    input  logic                 branch_taken,
    input  logic [WFID_W-1:0]    branch_wfid,
    input  logic [PC_W-1:0]      branch_target,
    input  logic [NUM_WF-1:0]    buff_full_vec,
    fetch_wave_scheduler_if.master imem,
    output logic                 fetch_valid,
    output logic [WFID_W-1:0]    fetch_wfid,
    output logic [PC_W-1:0]      fetch_pc,
    output logic [31:0]          fetch_instr
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t            state_q, state_d;
    logic [NUM_WF-1:0] active_q;
    logic [PC_W-1:0]   pc_q [NUM_WF];
    logic [WFID_W-1:0] rr_q;
    logic [WFID_W-1:0] req_wfid_q;
    logic [PC_W-1:0]   req_pc_q;
    logic              live_q;

    logic [NUM_WF-1:0] eligible;
    logic              grant_found;
    logic [WFID_W-1:0] grant_idx;
    logic              kill_hit;
    logic              resp_accept;

    assign imem.ip_req_valid = (state_q == S_REQ);
    assign imem.ip_req_pc    = req_pc_q;
    assign imem.ip_req_wfid  = req_wfid_q;

    // A slot halted this very cycle is already treated as gone.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_WF; i++) begin
            eligible[i] = active_q[i] & ~buff_full_vec[i]
                        & ~(wf_halt && halt_wfid == WFID_W'(i));
        end
    end

    // Round-robin search from rr_q+1 upward; scanning far-to-near lets the nearest hit win.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_WF; k >= 1; k--) begin
            if (eligible[WFID_W'((int'(rr_q) + k) % NUM_WF)]) begin
                grant_found = 1'b1;
                grant_idx   = WFID_W'((int'(rr_q) + k) % NUM_WF);
            end
        end
    end

    // Any dispatch/halt/branch touching the in-flight slot makes its response stale.
    always_comb begin
        kill_hit = (wf_dispatch_i && dispatch_wfid == req_wfid_q)
                || (wf_halt       && halt_wfid     == req_wfid_q)
                || (branch_taken  && branch_wfid   == req_wfid_q);
        resp_accept = (state_q == S_WAIT) && imem.ip_resp_valid && live_q && !kill_hit;
    end

    // Next-state logic for the single-outstanding request FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant_found)         state_d = S_REQ;
            S_REQ:   if (imem.ip_req_ready)   state_d = S_WAIT;
            S_WAIT:  if (imem.ip_resp_valid)  state_d = S_IDLE;
            default:                          state_d = S_IDLE;
        endcase
    end

    // Request registers, round-robin pointer, liveness and fetch outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_q        <= WFID_W'(NUM_WF - 1);
            req_wfid_q  <= '0;
            req_pc_q    <= '0;
            live_q      <= 1'b0;
            fetch_valid <= 1'b0;
            fetch_wfid  <= '0;
            fetch_pc    <= '0;
            fetch_instr <= '0;
        end else begin
            state_q     <= state_d;
            fetch_valid <= resp_accept;
            if (state_q == S_IDLE && grant_found) begin
                req_wfid_q <= grant_idx;
                req_pc_q   <= pc_q[grant_idx];
                rr_q       <= grant_idx;
                live_q     <= 1'b1;
            end else if (state_q != S_IDLE && kill_hit) begin
                live_q     <= 1'b0;
            end
            if (resp_accept) begin
                fetch_wfid  <= req_wfid_q;
                fetch_pc    <= req_pc_q;
                fetch_instr <= imem.ip_resp_instr;
            end
        end
    end

    // Per-slot state: dispatch > halt > branch > fetch increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= '0;
            for (int i = 0; i < NUM_WF; i++) pc_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_WF; i++) begin
                if (wf_dispatch_i && dispatch_wfid == WFID_W'(i)) begin
                    active_q[i] <= 1'b1;
                    pc_q[i]     <= dispatch_pc;
                end else if (wf_halt && halt_wfid == WFID_W'(i)) begin
                    active_q[i] <= 1'b0;
                end else if (branch_taken && branch_wfid == WFID_W'(i)) begin
                    pc_q[i]     <= branch_target;
                end else if (resp_accept && req_wfid_q == WFID_W'(i)) begin
                    pc_q[i]     <= req_pc_q + PC_W'(4);
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_wave_scheduler.sv
// Bench for fetch_wave_scheduler: directed scenarios followed by random
// traffic, all checked each cycle against a transaction-level model.
module tb_fetch_wave_scheduler;
    localparam int NUM_WF = 40;
    localparam int WFID_W = 6;
    localparam int PC_W   = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              wf_dispatch_i = 1'b0;
    logic [WFID_W-1:0] dispatch_wfid = '0;
    logic [PC_W-1:0]   dispatch_pc   = '0;
    logic              wf_halt       = 1'b0;
    logic [WFID_W-1:0] halt_wfid     = '0;
    logic              branch_taken  = 1'b0;
    logic [WFID_W-1:0] branch_wfid   = '0;
    logic [PC_W-1:0]   branch_target = '0;
    logic [NUM_WF-1:0] buff_full_vec = '0;
    logic              fetch_valid;
    logic [WFID_W-1:0] fetch_wfid;
    logic [PC_W-1:0]   fetch_pc;
    logic [31:0]       fetch_instr;

    fetch_wave_scheduler_if #(.PC_W(PC_W), .WFID_W(WFID_W)) imem();

    fetch_wave_scheduler #(.NUM_WF(NUM_WF), .WFID_W(WFID_W), .PC_W(PC_W)) dut (
        .clk(clk), .rst(rst),
        .wf_dispatch_i(wf_dispatch_i), .dispatch_wfid(dispatch_wfid), .dispatch_pc(dispatch_pc),
        .wf_halt(wf_halt), .halt_wfid(halt_wfid),
        .branch_taken(branch_taken), .branch_wfid(branch_wfid), .branch_target(branch_target),
        .buff_full_vec(buff_full_vec), .imem(imem),
        .fetch_valid(fetch_valid), .fetch_wfid(fetch_wfid), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: architectural per-slot state plus the in-flight transaction.
    bit          act_m   [NUM_WF];
    logic [31:0] pc_m    [NUM_WF];
    bit          elig_prev [NUM_WF];
    logic [31:0] pc_prev [NUM_WF];
    bit          idle_prev;
    int          rr_m;
    bit          txn_open, txn_acc, txn_live;
    int          txn_wfid;
    logic [31:0] txn_pc;
    bit          fv_exp;
    logic [5:0]  fw_exp;
    logic [31:0] fp_exp, fi_exp;

    int          grant_log [$];
    logic [31:0] rpc_log [$];
    logic [31:0] fpc_log [$];
    int          fwid_log [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit hits(input logic v, input logic [5:0] id, input int slot);
        return v && (int'(id) == slot);
    endfunction

    // Next owner: lowest eligible id above the last grant, else lowest eligible id.
    function automatic int pick(input int rr);
        int best = -1;
        int lowest = -1;
        for (int i = 0; i < NUM_WF; i++) begin
            if (elig_prev[i]) begin
                if (lowest < 0) lowest = i;
                if (i > rr && best < 0) best = i;
            end
        end
        return (best >= 0) ? best : lowest;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_WF; i++) begin
            act_m[i] = 0; pc_m[i] = '0; elig_prev[i] = 0; pc_prev[i] = '0;
        end
        idle_prev = 1; rr_m = NUM_WF - 1;
        txn_open = 0; txn_acc = 0; txn_live = 0; txn_wfid = 0; txn_pc = '0;
        fv_exp = 0; fw_exp = '0; fp_exp = '0; fi_exp = '0;
        grant_log.delete(); rpc_log.delete(); fpc_log.delete(); fwid_log.delete();
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear at once.
    task automatic do_reset();
        rst = 1'b1;
        wf_dispatch_i = 0; wf_halt = 0; branch_taken = 0;
        #1;
        chk("rst_req_valid", imem.ip_req_valid, 0);
        chk("rst_req_pc", imem.ip_req_pc, 0);
        chk("rst_req_wfid", imem.ip_req_wfid, 0);
        chk("rst_fetch_valid", fetch_valid, 0);
        chk("rst_fetch_wfid", fetch_wfid, 0);
        chk("rst_fetch_pc", fetch_pc, 0);
        chk("rst_fetch_instr", fetch_instr, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock: check outputs, advance the model with this cycle's inputs, clock.
    task automatic tick();
        bit any = 0;
        bit exp_rv;
        bit hs;
        int g;
        int upd_slot = -1;
        logic [31:0] upd_pc = '0;
        for (int i = 0; i < NUM_WF; i++) if (elig_prev[i]) any = 1;
        exp_rv = txn_open ? !txn_acc : (idle_prev && any);
        chk("req_valid", imem.ip_req_valid, exp_rv);
        if (!txn_open && exp_rv) begin
            g = pick(rr_m);
            txn_open = 1; txn_acc = 0; txn_live = 1;
            txn_wfid = g; txn_pc = pc_prev[g]; rr_m = g;
            grant_log.push_back(int'(imem.ip_req_wfid));
            rpc_log.push_back(imem.ip_req_pc);
        end
        if (txn_open && !txn_acc) begin
            chk("req_wfid", imem.ip_req_wfid, txn_wfid);
            chk("req_pc", imem.ip_req_pc, txn_pc);
        end
        chk("fetch_valid", fetch_valid, fv_exp);
        chk("fetch_wfid", fetch_wfid, fw_exp);
        chk("fetch_pc", fetch_pc, fp_exp);
        chk("fetch_instr", fetch_instr, fi_exp);
        if (fetch_valid) begin
            fpc_log.push_back(fetch_pc);
            fwid_log.push_back(int'(fetch_wfid));
        end
        if (txn_open && (hits(wf_dispatch_i, dispatch_wfid, txn_wfid) ||
                         hits(wf_halt, halt_wfid, txn_wfid) ||
                         hits(branch_taken, branch_wfid, txn_wfid)))
            txn_live = 0;
        hs = txn_open && !txn_acc && imem.ip_req_ready;
        idle_prev = !txn_open;
        for (int i = 0; i < NUM_WF; i++) begin
            elig_prev[i] = act_m[i] && !buff_full_vec[i] && !hits(wf_halt, halt_wfid, i);
            pc_prev[i]   = pc_m[i];
        end
        fv_exp = 0;
        if (txn_open && txn_acc && imem.ip_resp_valid) begin
            if (txn_live) begin
                fv_exp = 1; fw_exp = 6'(txn_wfid); fp_exp = txn_pc; fi_exp = imem.ip_resp_instr;
                upd_slot = txn_wfid; upd_pc = txn_pc + 32'd4;
            end
            txn_open = 0;
        end
        if (hs) txn_acc = 1;
        for (int i = 0; i < NUM_WF; i++) begin
            if (hits(wf_dispatch_i, dispatch_wfid, i)) begin act_m[i] = 1; pc_m[i] = dispatch_pc; end
            else if (hits(wf_halt, halt_wfid, i)) act_m[i] = 0;
            else if (hits(branch_taken, branch_wfid, i)) pc_m[i] = branch_target;
            else if (i == upd_slot) pc_m[i] = upd_pc;
        end
        @(posedge clk);
        @(negedge clk);
        wf_dispatch_i = 0; wf_halt = 0; branch_taken = 0;
    endtask

    task automatic dispatch(input int id, input logic [31:0] pc);
        wf_dispatch_i = 1; dispatch_wfid = 6'(id); dispatch_pc = pc;
        tick();
    endtask

    task automatic wait_acc(input int max_cycles);
        for (int n = 0; n < max_cycles && !txn_acc; n++) tick();
        chk("wait_accept_timeout", txn_acc, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt2;
        imem.ip_req_ready = 0; imem.ip_resp_valid = 0; imem.ip_resp_instr = '0;
        @(negedge clk);

        // Reset abandons an outstanding request; later responses are ignored.
        do_reset();
        imem.ip_req_ready = 1;
        dispatch(4, 32'h80);
        wait_acc(10);
        do_reset();
        imem.ip_resp_valid = 1;
        repeat (5) tick();
        chk("t1_no_fetch", fpc_log.size(), 0);

        // Sequential fetch of one wavefront.
        do_reset();
        imem.ip_req_ready = 1; imem.ip_resp_valid = 1;
        dispatch(3, 32'h100);
        for (int n = 0; n < 15; n++) begin imem.ip_resp_instr = $urandom; tick(); end
        chk("t2_count", fpc_log.size() >= 3, 1);
        if (fpc_log.size() >= 3) begin
            chk("t2_pc0", fpc_log[0], 32'h100);
            chk("t2_pc1", fpc_log[1], 32'h104);
            chk("t2_pc2", fpc_log[2], 32'h108);
            chk("t2_wfid", fwid_log[2], 3);
        end

        // Round-robin order with wrap.
        do_reset();
        imem.ip_req_ready = 1; imem.ip_resp_valid = 1;
        dispatch(1, 32'h1000); dispatch(5, 32'h5000); dispatch(39, 32'h9000);
        repeat (20) tick();
        chk("t3_count", grant_log.size() >= 5, 1);
        if (grant_log.size() >= 5) begin
            chk("t3_g0", grant_log[0], 1);
            chk("t3_g1", grant_log[1], 5);
            chk("t3_g2", grant_log[2], 39);
            chk("t3_g3", grant_log[3], 1);
            chk("t3_g4", grant_log[4], 5);
        end

        // Full instruction buffer blocks fetch until cleared.
        do_reset();
        imem.ip_req_ready = 1; imem.ip_resp_valid = 1;
        buff_full_vec[5] = 1'b1;
        dispatch(5, 32'h500);
        repeat (10) tick();
        chk("t4_blocked", grant_log.size(), 0);
        buff_full_vec[5] = 1'b0;
        tick(); tick();
        chk("t4_released", grant_log.size(), 1);
        if (grant_log.size() == 1) chk("t4_wfid", grant_log[0], 5);

        // Branch during WAIT drops the response and redirects the next request.
        do_reset();
        imem.ip_req_ready = 1; imem.ip_resp_valid = 0;
        dispatch(2, 32'h20);
        wait_acc(10);
        branch_taken = 1; branch_wfid = 6'd2; branch_target = 32'h400;
        tick();
        imem.ip_resp_valid = 1; imem.ip_resp_instr = 32'hDEAD_BEEF;
        tick();
        imem.ip_resp_valid = 0;
        repeat (6) tick();
        chk("t5_dropped", fpc_log.size(), 0);
        chk("t5_reqs", rpc_log.size(), 2);
        if (rpc_log.size() == 2) chk("t5_redirect_pc", rpc_log[1], 32'h400);

        // Halt coincident with response; request held while memory stalls.
        do_reset();
        imem.ip_req_ready = 1; imem.ip_resp_valid = 0;
        dispatch(2, 32'h40); dispatch(7, 32'h700);
        wait_acc(10);
        wf_halt = 1; halt_wfid = 6'd2; imem.ip_resp_valid = 1;
        tick();
        imem.ip_resp_valid = 0; imem.ip_req_ready = 0;
        repeat (14) tick();
        chk("t6_hold_valid", imem.ip_req_valid, 1);
        chk("t6_hold_wfid", imem.ip_req_wfid, 7);
        chk("t6_hold_pc", imem.ip_req_pc, 32'h700);
        chk("t6_dropped", fpc_log.size(), 0);
        imem.ip_req_ready = 1; imem.ip_resp_valid = 1;
        repeat (12) tick();
        cnt2 = 0;
        foreach (grant_log[i]) if (grant_log[i] == 2) cnt2++;
        chk("t6_wf2_once", cnt2, 1);
        chk("t6_fetched", fwid_log.size() >= 2, 1);
        foreach (fwid_log[i]) chk("t6_fetch_wfid", fwid_log[i], 7);

        // Random traffic, including out-of-range ids and spurious responses.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            if ($urandom_range(0, 5) == 0) begin
                wf_dispatch_i = 1;
                dispatch_wfid = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(40, 63)) : 6'($urandom_range(0, 39));
                dispatch_pc   = {$urandom_range(0, 65535), 2'b00};
            end
            if ($urandom_range(0, 11) == 0) begin
                wf_halt = 1; halt_wfid = 6'($urandom_range(0, 45));
            end
            if ($urandom_range(0, 7) == 0) begin
                branch_taken = 1; branch_wfid = 6'($urandom_range(0, 45));
                branch_target = {$urandom_range(0, 65535), 2'b00};
            end
            if ($urandom_range(0, 15) == 0) begin
                for (int i = 0; i < NUM_WF; i++) buff_full_vec[i] = ($urandom_range(0, 3) == 0);
            end
            imem.ip_req_ready  = ($urandom_range(0, 1) == 1);
            imem.ip_resp_valid = ($urandom_range(0, 2) == 0);
            imem.ip_resp_instr = $urandom;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
